sent_tx_pulse_gen: RTL
======================

// Module: sent_tx_pulse_gen
// PURPOSE
//  Downstream of sent_tx_crc_gen. Accepts one fast-channel frame: status nibble, 3/4/6 data nibbles and crc_fast.
//  Serialises it onto the SENT line as tick-timed pulses: sync, status, data, CRC and an optional pause.
//  Output line idles high. Every pulse is LOW_TICKS low, then high for the rest of the pulse.
// PARAMETERS
//  TICK_DIV    3    clk cycles per SENT tick (>=1)
//  LOW_TICKS   5    low-phase length of every pulse, in ticks
//  PAUSE_EN    1    1: append pause pulse so the frame lasts FRAME_TICKS
//  FRAME_TICKS 282  target frame length in ticks when PAUSE_EN=1
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-low reset
//  frame_valid   in   1   frame request; held until accepted
//  frame_ready   out  1   block can accept a frame this cycle
//  nibble_mode   in   2   0:3 nibbles, 1:4, 2:6, 3:treated as 6
//  status_nibble in   4   status/communication nibble
//  data_nibbles  in   24  data in [4N-1:0], sent MS nibble first
//  crc_in        in   4   crc_fast from sent_tx_crc_gen for the same data
//  sent_out      out  1   SENT line
//  busy          out  1   frame in progress
//  frame_done    out  1   1-cycle pulse on the last clk of a frame
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - state=IDLE, sent_out=1, busy=0, frame_done=0, all counters 0.
//    - Applies mid-frame: the line returns high on the next edge, the frame is abandoned, no frame_done.
//  - Handshake:
//    - Accept when frame_valid&&frame_ready. Inputs are latched on that edge; later input changes are ignored.
//    - frame_ready = (state==IDLE) || last clk of the final pulse. Back-to-back frames have no idle gap.
//  - Latency: sent_out goes low on the clk edge after acceptance. The prescaler restarts at 0 on accept.
//  - Prescaler: tick_en pulses every TICK_DIV clks and runs only while busy.
//  - Pulse timing: each pulse lasts P ticks (P*TICK_DIV clks).
//    - sent_out=0 for the first LOW_TICKS ticks, then 1.
//    - SYNC: P=56.
//    - STATUS/DATA/CRC: P=12+nibble value (12..27).
//  - FSM: IDLE -> SYNC -> STATUS -> DATA(xN) -> CRC -> PAUSE (if PAUSE_EN) -> IDLE/SYNC.
//    - A nibble index counts N-1 down to 0.
//    - Each transition fires on the tick_en that completes the pulse.
//  - Pause: used = total ticks of sync..CRC (9-bit accumulator).
//    - P_pause = FRAME_TICKS-used, floored at 12 when that difference is <12.
//  - Frame end:
//    - frame_done asserts on the last clk of CRC (PAUSE_EN=0) or of PAUSE.
//    - Next state is SYNC if a frame is accepted that cycle, otherwise IDLE with sent_out=1.
//  - busy=1 from the accept edge until the frame ends without a new accept.
//  - frame_valid is ignored while frame_ready=0. No overflow is possible; max used is 272 ticks.
// STRUCTURE
//  - sent_pkg: SYNC_TICKS=56, NIBBLE_BASE=12, PAUSE_MIN=12, state enum {IDLE,SYNC,STATUS,DATA,CRC,PAUSE}, mode encodings.
//  - Sub-module sent_tx_tick_gen: prescaler (clk, reset, run, tick_en).
//  - Top level holds the FSM, pulse tick counter, low-phase compare and frame accumulator.
// TESTING (TICK_DIV=3, LOW_TICKS=5, FRAME_TICKS=282)
//  1. Reset, idle -> sent_out=1, frame_ready=1, busy=0.
//  2. Mode 0, status 0, data 0x2C7, crc 0xD, PAUSE_EN=0.
//     -> pulses 56,12,14,24,19,25 ticks (168,36,42,72,57,75 clks).
//     -> Each pulse has 15 low clks. frame_done on clk 450 after accept.
//  3. Same frame, PAUSE_EN=1 -> pause of 282-150=132 ticks. Frame = 846 clks. frame_done on the last clk.
//  4. Mode 2, all nibbles 0xF, crc 0xF -> used 272, pause floored to 12 ticks, frame 284 ticks.
//  5. frame_valid held high continuously -> second sync falls on the clk right after frame_done. No high gap.
//  6. reset low mid-DATA -> sent_out=1, state IDLE next edge, no frame_done. The next frame times correctly.

Source files
------------

// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - shared constants, state encoding and helpers for the SENT transmitter
// Purpose: pulse-length constants, nibble-mode encodings, FSM state type and small
//          helpers used by the SENT pulse generator.
package sent_pkg;

  localparam int SYNC_TICKS  = 56;
  localparam int NIBBLE_BASE = 12;
  localparam int PAUSE_MIN   = 12;

  localparam logic [1:0] MODE_3  = 2'd0;
  localparam logic [1:0] MODE_4  = 2'd1;
  localparam logic [1:0] MODE_6  = 2'd2;
  localparam logic [1:0] MODE_6X = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    STATUS,
    DATA,
    CRC,
    PAUSE
  } state_t;

  // Index of the most significant data nibble for a given mode; the data
  // phase walks this index down to 0.
  function automatic logic [2:0] last_nibble_idx(input logic [1:0] mode);
    case (mode)
      MODE_3:  return 3'd2;
      MODE_4:  return 3'd3;
      MODE_6:  return 3'd5;
      MODE_6X: return 3'd5;
      default: return 3'd5;
    endcase
  endfunction

  // Pulse length in ticks for a nibble-carrying pulse.
  function automatic logic [8:0] nibble_ticks(input logic [3:0] nib);
    return 9'(NIBBLE_BASE) + {5'd0, nib};
  endfunction

endpackage

// File: rtl/sent_tx_tick_gen.sv
// rtl/sent_tx_tick_gen.sv - SENT tick prescaler
// Purpose: emits a one-clk tick_en every TICK_DIV clks while run is high.
//          The count is held at 0 whenever run is low, so a frame started
//          from idle always begins with a full tick.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-low reset
//   run     in  prescaler enable (frame in progress)
//   tick_en out one-clk pulse on the last clk of each tick
module sent_tx_tick_gen #(
  parameter int TICK_DIV = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick_en
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || tick_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_en = run && (cnt == LAST);

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// rtl/sent_tx_pulse_gen.sv - SENT fast-channel frame serialiser
// Purpose: accepts one frame (status, 3/4/6 data nibbles, CRC) and drives it
//          onto the SENT line as tick-timed pulses: sync, status, data, CRC
//          and an optional pause that pads the frame to FRAME_TICKS.
// Ports:
//   clk           in  system clock
//   reset         in  synchronous active-low reset
//   frame_valid   in  frame request, held until accepted
//   frame_ready   out frame can be accepted this clk
//   nibble_mode   in  0:3 nibbles, 1:4, 2:6, 3:6
//   status_nibble in  status nibble
//   data_nibbles  in  data in [4N-1:0], MS nibble sent first
//   crc_in        in  CRC nibble for the frame
//   sent_out      out SENT line (idles high)
//   busy          out frame in progress
//   frame_done    out one-clk pulse on the last clk of a frame
module sent_tx_pulse_gen #(
  parameter int TICK_DIV    = 3,
  parameter int LOW_TICKS   = 5,
  parameter int PAUSE_EN    = 1,
  parameter int FRAME_TICKS = 282
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [1:0]  nibble_mode,
  input  logic [3:0]  status_nibble,
  input  logic [23:0] data_nibbles,
  input  logic [3:0]  crc_in,
  output logic        sent_out,
  output logic        busy,
  output logic        frame_done
);

  import sent_pkg::*;

  localparam logic [8:0] LOW_T   = 9'(LOW_TICKS);
  localparam logic [9:0] FRAME_T = 10'(FRAME_TICKS);

  state_t      state, state_next;
  logic [8:0]  tick_cnt, tick_next;
  logic [8:0]  used, used_next;
  logic [2:0]  idx, idx_next;
  logic [1:0]  mode_q;
  logic [3:0]  status_q;
  logic [3:0]  crc_q;
  logic [23:0] data_q;

  logic        tick_en;
  logic        pulse_end;
  logic        last_pulse;
  logic        accept;
  logic        load;
  logic [3:0]  cur_nibble;
  logic [8:0]  pulse_len;
  logic [8:0]  pause_len;

  sent_tx_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (busy),
    .tick_en (tick_en)
  );

  assign busy       = (state != IDLE);
  assign cur_nibble = data_q[{idx, 2'b00} +: 4];

  // Pause pads the frame to FRAME_TICKS but never drops below PAUSE_MIN.
  always_comb begin
    pause_len = 9'(PAUSE_MIN);
    if (({1'b0, used} + 10'(PAUSE_MIN)) <= FRAME_T) begin
      pause_len = 9'(FRAME_T - {1'b0, used});
    end
  end

  always_comb begin
    pulse_len = 9'(SYNC_TICKS);
    case (state)
      SYNC:    pulse_len = 9'(SYNC_TICKS);
      STATUS:  pulse_len = nibble_ticks(status_q);
      DATA:    pulse_len = nibble_ticks(cur_nibble);
      CRC:     pulse_len = nibble_ticks(crc_q);
      PAUSE:   pulse_len = pause_len;
      default: pulse_len = 9'(SYNC_TICKS);
    endcase
  end

  assign pulse_end   = tick_en && (tick_cnt == pulse_len - 9'd1);
  assign last_pulse  = (state == PAUSE) || ((state == CRC) && (PAUSE_EN == 0));
  assign frame_done  = pulse_end && last_pulse;
  assign frame_ready = (state == IDLE) || frame_done;
  assign accept      = frame_valid && frame_ready;

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    used_next  = used;
    idx_next   = idx;
    load       = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        state_next = SYNC;
        tick_next  = '0;
        used_next  = '0;
        load       = 1'b1;
      end
    end else if (tick_en) begin
      if (!pulse_end) begin
        tick_next = tick_cnt + 9'd1;
      end else begin
        tick_next = '0;
        used_next = used + pulse_len;
        case (state)
          SYNC:   state_next = STATUS;
          STATUS: begin
            state_next = DATA;
            idx_next   = last_nibble_idx(mode_q);
          end
          DATA: begin
            if (idx == 3'd0) state_next = CRC;
            else             idx_next   = idx - 3'd1;
          end
          CRC: begin
            if (PAUSE_EN != 0) state_next = PAUSE;
          end
          default: state_next = state;
        endcase
        // Frame end: chain straight into the next sync when a frame is
        // accepted on this same clk, otherwise drop back to idle.
        if (last_pulse) begin
          if (accept) begin
            state_next = SYNC;
            used_next  = '0;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      used     <= '0;
      idx      <= '0;
      mode_q   <= '0;
      status_q <= '0;
      crc_q    <= '0;
      data_q   <= '0;
      sent_out <= 1'b1;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      used     <= used_next;
      idx      <= idx_next;
      if (load) begin
        mode_q   <= nibble_mode;
        status_q <= status_nibble;
        crc_q    <= crc_in;
        data_q   <= data_nibbles;
      end
      // Registered line: low for the first LOW_TICKS ticks of every pulse.
      sent_out <= (state_next == IDLE) || (tick_next >= LOW_T);
    end
  end

endmodule
